// File: rtl/nem_ohmux_pkg.sv
// rtl/nem_ohmux_pkg.sv - shared types and helpers for the NEM one-hot relay mux
package nem_ohmux_pkg;

    // Sequencer states: relays open, forced break gap, make/settle wait, settled
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_ON    = 2'd3
    } state_e;

    // Widest select bus the decode helper supports; callers cast down to N_IN
    localparam int unsigned OH_MAX = 32;

    // Binary index to one-hot select vector
    function automatic logic [OH_MAX-1:0] onehot(input logic [4:0] idx);
        logic [OH_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Value of each ZN bit when no relay is closed: AOI idles high, AND-OR idles low
    function automatic logic idle_zn_bit(input int invert);
        return (invert != 0);
    endfunction

endpackage

// File: rtl/nem_ohmux_core.sv
// rtl/nem_ohmux_core.sv - combinational N_IN x WIDTH AND-OR(-INVERT) relay mux datapath
module nem_ohmux_core #(
    parameter int N_IN   = 4,
    parameter int WIDTH  = 8,
    parameter int INVERT = 1
) (
    input  logic [N_IN-1:0]       s_i,
    input  logic [N_IN*WIDTH-1:0] d_i,
    output logic [WIDTH-1:0]      zn_o
);

    logic [WIDTH-1:0] raw;

    // OR together every input whose select relay is closed
    always_comb begin
        raw = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (s_i[k]) begin
                raw = raw | d_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign zn_o = (INVERT != 0) ? ~raw : raw;

endmodule

// File: rtl/nem_ohmux_bbm.sv
// rtl/nem_ohmux_bbm.sv - one-hot NEM relay mux with break-before-make select sequencer
module nem_ohmux_bbm
    import nem_ohmux_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int WIDTH   = 8,
    parameter int T_BREAK = 2,
    parameter int T_MAKE  = 3,
    parameter int INVERT  = 1
) (
    input  logic                    CP,
    input  logic                    CDN,
    input  logic [N_IN*WIDTH-1:0]   I,
    input  logic                    SEL_VLD,
    output logic                    SEL_RDY,
    input  logic [$clog2(N_IN)-1:0] SEL_IDX,
    input  logic                    SEL_OFF,
    output logic [N_IN-1:0]         S,
    output logic [WIDTH-1:0]        ZN,
    output logic                    ZN_VLD,
    output logic                    ERR,
    input  logic                    ERR_CLR
);

    localparam int IW   = $clog2(N_IN);
    localparam int TMAX = (T_BREAK > T_MAKE) ? T_BREAK : T_MAKE;
    localparam int CW   = $clog2(TMAX + 1);

    // Counters load "cycles minus one" so the transition lands exactly T cycles after entry
    localparam logic [CW-1:0]    LD_BREAK = CW'(T_BREAK - 1);
    localparam logic [CW-1:0]    LD_MAKE  = CW'(T_MAKE - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [IW:0]      N_LIM    = (IW + 1)'(N_IN);
    localparam logic [WIDTH-1:0] ZN_IDLE  = {WIDTH{idle_zn_bit(INVERT)}};

    state_e          st_q;
    logic [N_IN-1:0] s_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   cur_q;
    logic [IW-1:0]   tgt_q;
    logic            off_q;
    logic            rdy_q;
    logic            vld_q;
    logic            err_q;
    logic            err_d;
    logic [WIDTH-1:0] zn_q;
    logic [WIDTH-1:0] zn_d;

    logic            accept;
    logic            idx_ok;
    logic [N_IN-1:0] req_oh;
    logic [N_IN-1:0] tgt_oh;

    assign accept = SEL_VLD & rdy_q;
    assign idx_ok = ({1'b0, SEL_IDX} < N_LIM);
    assign req_oh = N_IN'(onehot(5'(SEL_IDX)));
    assign tgt_oh = N_IN'(onehot(5'(tgt_q)));

    // Select sequencer: never closes a new relay until every relay has been open T_BREAK cycles
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            st_q  <= ST_OFF;
            s_q   <= '0;
            cnt_q <= '0;
            cur_q <= '0;
            tgt_q <= '0;
            off_q <= 1'b0;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
        end else begin
            case (st_q)
                ST_OFF: begin
                    // Nothing is closed, so a make can start immediately
                    if (accept && !SEL_OFF && idx_ok) begin
                        st_q  <= ST_MAKE;
                        s_q   <= req_oh;
                        cur_q <= SEL_IDX;
                        cnt_q <= LD_MAKE;
                        rdy_q <= 1'b0;
                        vld_q <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (accept && SEL_OFF) begin
                        st_q  <= ST_BREAK;
                        s_q   <= '0;
                        off_q <= 1'b1;
                        cnt_q <= LD_BREAK;
                        rdy_q <= 1'b0;
                        vld_q <= 1'b0;
                    end else if (accept && idx_ok && (SEL_IDX != cur_q)) begin
                        st_q  <= ST_BREAK;
                        s_q   <= '0;
                        off_q <= 1'b0;
                        tgt_q <= SEL_IDX;
                        cnt_q <= LD_BREAK;
                        rdy_q <= 1'b0;
                        vld_q <= 1'b0;
                    end
                end
                ST_BREAK: begin
                    if (cnt_q == '0) begin
                        if (off_q) begin
                            st_q  <= ST_OFF;
                            rdy_q <= 1'b1;
                        end else begin
                            st_q  <= ST_MAKE;
                            s_q   <= tgt_oh;
                            cur_q <= tgt_q;
                            cnt_q <= LD_MAKE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_MAKE: begin
                    if (cnt_q == '0) begin
                        st_q  <= ST_ON;
                        rdy_q <= 1'b1;
                        vld_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    st_q  <= ST_OFF;
                    s_q   <= '0;
                    rdy_q <= 1'b1;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky range error; a new bad index wins over a same-cycle clear
    always_comb begin
        err_d = err_q;
        if (accept && !SEL_OFF && !idx_ok) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end
    end

    // Error flag register
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    nem_ohmux_core #(
        .N_IN   (N_IN),
        .WIDTH  (WIDTH),
        .INVERT (INVERT)
    ) u_core (
        .s_i  (s_q),
        .d_i  (I),
        .zn_o (zn_d)
    );

    // Register the mux output from the currently driven relay selects
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            zn_q <= ZN_IDLE;
        end else begin
            zn_q <= zn_d;
        end
    end

    a_sel_onehot0: assert property (@(posedge CP) disable iff (!CDN) $onehot0(s_q))
        else $error("relay selects overlap: %b", s_q);

    assign S       = s_q;
    assign ZN      = zn_q;
    assign ZN_VLD  = vld_q;
    assign SEL_RDY = rdy_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_nem_ohmux_bbm.sv
// tb/tb_nem_ohmux_bbm.sv - self-checking scoreboard bench for nem_ohmux_bbm
module tb_nem_ohmux_bbm;

    localparam int TB = 2;

    logic        cp = 1'b0;
    logic        cdn;
    logic [31:0] i_bus;
    logic        sel_vld, sel_off, err_clr, sel_rdy, zn_vld, err;
    logic [1:0]  sel_idx;
    logic [3:0]  s;
    logic [7:0]  zn;

    logic [23:0] i3;
    logic        sel_vld3, sel_off3, err_clr3, sel_rdy3, zn_vld3, err3;
    logic [1:0]  sel_idx3;
    logic [2:0]  s3;
    logic [7:0]  zn3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] s;
        logic [7:0] zn;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 cp = ~cp;

    nem_ohmux_bbm #(.N_IN(4), .WIDTH(8), .T_BREAK(2), .T_MAKE(3), .INVERT(1)) u_dut (
        .CP(cp), .CDN(cdn), .I(i_bus), .SEL_VLD(sel_vld), .SEL_RDY(sel_rdy),
        .SEL_IDX(sel_idx), .SEL_OFF(sel_off), .S(s), .ZN(zn), .ZN_VLD(zn_vld),
        .ERR(err), .ERR_CLR(err_clr)
    );

    nem_ohmux_bbm #(.N_IN(3), .WIDTH(8), .T_BREAK(2), .T_MAKE(3), .INVERT(1)) u_dut3 (
        .CP(cp), .CDN(cdn), .I(i3), .SEL_VLD(sel_vld3), .SEL_RDY(sel_rdy3),
        .SEL_IDX(sel_idx3), .SEL_OFF(sel_off3), .S(s3), .ZN(zn3), .ZN_VLD(zn_vld3),
        .ERR(err3), .ERR_CLR(err_clr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    // Drive one request for a single edge; state-changing requests queue their expected outcome
    task automatic issue(input logic [1:0] idx, input logic off, input int lat,
                         input logic [3:0] s_exp, input logic [7:0] zn_exp, input string tag);
        exp_t e;
        if (lat > 0) begin
            e.tag = tag;
            e.s   = s_exp;
            e.zn  = zn_exp;
            e.lat = lat;
            sb_q.push_back(e);
        end
        sel_idx = idx;
        sel_off = off;
        sel_vld = 1'b1;
        tick();
        sel_vld = 1'b0;
        sel_off = 1'b0;
    endtask

    // Wait (bounded) for ZN_VLD, then pop the oldest expectation and compare
    task automatic settle(input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (!zn_vld && n < 40) begin
            check("onehot0", {31'd0, $onehot0(s)}, 32'd1);
            tick();
            n++;
        end
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_lat"}, n, e.lat);
            check({e.tag, "_s"}, {28'd0, s}, {28'd0, e.s});
            check({e.tag, "_zn"}, {24'd0, zn}, {24'd0, e.zn});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cdn = 1'b0;
        sel_vld = 1'b0; sel_off = 1'b0; err_clr = 1'b0; sel_idx = '0;
        sel_vld3 = 1'b0; sel_off3 = 1'b0; err_clr3 = 1'b0; sel_idx3 = '0;
        i_bus = $urandom();
        i3 = 24'($urandom());
        repeat (3) tick();

        // 1. reset state
        check("rst_s", {28'd0, s}, 32'h0);
        check("rst_zn", {24'd0, zn}, 32'hFF);
        check("rst_vld", {31'd0, zn_vld}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        cdn = 1'b1;
        #1;
        check("rst_rdy", {31'd0, sel_rdy}, 32'd1);
        tick();

        // 2. make from OFF
        i_bus[23:16] = 8'hA5;
        issue(2'd2, 1'b0, 3, 4'b0100, 8'h5A, "t2");
        check("t2_s_accept", {28'd0, s}, 32'h4);
        check("t2_vld_accept", {31'd0, zn_vld}, 32'd0);
        settle(0);

        // 3. change from ON: break then make
        i_bus[7:0] = 8'h0F;
        issue(2'd0, 1'b0, 5, 4'b0001, 8'hF0, "t3");
        for (int c = 0; c < 5; c++) begin
            check("t3_s", {28'd0, s}, (c < TB) ? 32'h0 : 32'h1);
            check("t3_rdy", {31'd0, sel_rdy}, 32'd0);
            check("t3_vld", {31'd0, zn_vld}, 32'd0);
            tick();
        end
        settle(5);

        // 4. same-index no-op, then SEL_OFF
        i_bus[15:8] = 8'h3C;
        issue(2'd1, 1'b0, 5, 4'b0010, 8'hC3, "t4");
        settle(0);
        issue(2'd1, 1'b0, 0, 4'b0010, 8'hC3, "t4_same");
        check("t4_same_s", {28'd0, s}, 32'h2);
        check("t4_same_vld", {31'd0, zn_vld}, 32'd1);
        check("t4_same_rdy", {31'd0, sel_rdy}, 32'd1);
        issue(2'd0, 1'b1, 0, 4'b0000, 8'hFF, "t4_off");
        check("t4_off_s", {28'd0, s}, 32'h0);
        check("t4_off_vld", {31'd0, zn_vld}, 32'd0);
        check("t4_off_rdy0", {31'd0, sel_rdy}, 32'd0);
        tick();
        check("t4_off_rdy1", {31'd0, sel_rdy}, 32'd0);
        tick();
        check("t4_off_rdy2", {31'd0, sel_rdy}, 32'd1);
        check("t4_off_zn", {24'd0, zn}, 32'hFF);
        check("t4_off_s2", {28'd0, s}, 32'h0);

        // 5. out-of-range index on a 3-input mux
        sel_idx3 = 2'd3;
        sel_vld3 = 1'b1;
        tick();
        sel_vld3 = 1'b0;
        check("t5_err_set", {31'd0, err3}, 32'd1);
        check("t5_s", {29'd0, s3}, 32'h0);
        check("t5_rdy", {31'd0, sel_rdy3}, 32'd1);
        check("t5_vld", {31'd0, zn_vld3}, 32'd0);
        err_clr3 = 1'b1;
        tick();
        err_clr3 = 1'b0;
        check("t5_err_clr", {31'd0, err3}, 32'd0);
        err_clr3 = 1'b1;
        sel_vld3 = 1'b1;
        tick();
        err_clr3 = 1'b0;
        sel_vld3 = 1'b0;
        check("t5_err_prio", {31'd0, err3}, 32'd1);
        check("t5_main_err", {31'd0, err}, 32'd0);

        // 6. reset pulse during MAKE
        issue(2'd1, 1'b0, 0, 4'b0010, 8'hC3, "t6_drop");
        tick();
        check("t6_make_s", {28'd0, s}, 32'h2);
        cdn = 1'b0;
        #1;
        check("t6_rst_s", {28'd0, s}, 32'h0);
        check("t6_rst_zn", {24'd0, zn}, 32'hFF);
        check("t6_rst_vld", {31'd0, zn_vld}, 32'd0);
        tick();
        cdn = 1'b1;
        #1;
        check("t6_rel_rdy", {31'd0, sel_rdy}, 32'd1);
        check("t6_rel_s", {28'd0, s}, 32'h0);
        i_bus[31:24] = 8'h81;
        issue(2'd3, 1'b0, 3, 4'b1000, 8'h7E, "t6");
        check("t6_s_accept", {28'd0, s}, 32'h8);
        settle(0);

        check("sb_drain", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
